// File: rtl/uart_rxd.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling FSM,
// small receive FIFO with sticky framing and overrun flags.
module uart_rxd #(
  parameter int BIT_CLKS  = 208,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 rd,
  input  logic                 clr,
  output logic [7:0]           q,
  output logic                 ready,
  output logic [FIFO_LOG2:0]   count,
  output logic                 ferr,
  output logic                 ovr
);

  localparam int CW    = $clog2(BIT_CLKS);
  localparam int DEPTH = 1 << FIFO_LOG2;

  localparam logic [CW-1:0]      HALF_LOAD = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0]      FULL_LOAD = CW'(BIT_CLKS - 1);
  localparam logic [FIFO_LOG2:0] DEPTH_CNT = {1'b1, {FIFO_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Synchronizer and edge history; all reset high so a released reset
  // never looks like a fresh start bit on an idle line.
  logic sync_0, s, s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_0 <= 1'b1;
      s      <= 1'b1;
      s_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous
      // stage's old value, giving a true shift chain rather than a wire.
      sync_0 <= rxd;
      s      <= sync_0;
      s_d    <= s;
    end
  end

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          push, frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    push      = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      IDLE: begin
        // Edge-triggered start: a line parked low never retriggers.
        if (s_d && !s) begin
          state_nxt = START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = FULL_LOAD;
            idx_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_nxt[idx] = s;
          cnt_nxt        = FULL_LOAD;
          idx_nxt        = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          if (s) push      = 1'b1;
          else   frame_err = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Receive FIFO. When full, a push that coincides with a pop reuses the
  // slot being vacated (tail == head), so contents stay ordered.
  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] head, tail;
  logic                 pop, full, wr_en, ovr_set;

  assign ready   = (count != '0);
  assign full    = (count == DEPTH_CNT);
  assign pop     = rd && ready;
  assign wr_en   = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign q       = mem[head];

  // NOTE: the storage array is deliberately left out of reset; pointers and
  // count define validity, and unreset arrays map onto plain register files.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (wr_en) tail <= tail + 1'b1;
      if (pop)   head <= head + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Setting events take priority over a coincident clear.
      if (frame_err) ferr <= 1'b1;
      else if (clr)  ferr <= 1'b0;
      if (ovr_set)   ovr <= 1'b1;
      else if (clr)  ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rxd.sv
// Bench for uart_rxd at BIT_CLKS=16, 4-entry FIFO: directed frames, with a
// scoreboard of expected bytes and status snapshots checked by one monitor.
module tb_uart_rxd;

  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       reset, rxd, rd, clr;
  logic [7:0] q;
  logic       ready;
  logic [2:0] count;
  logic       ferr, ovr;

  uart_rxd #(.BIT_CLKS(BC), .FIFO_LOG2(2)) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .rd    (rd),
    .clr   (clr),
    .q     (q),
    .ready (ready),
    .count (count),
    .ferr  (ferr),
    .ovr   (ovr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  tag;
    logic [3:0]  cnt;
    logic        ferr;
    logic        ovr;
    logic        lat_chk;
    logic        sb_chk;
    logic [15:0] lat;
  } req_t;

  logic [7:0] exp_q [$];
  req_t       req_q [$];
  int         checks = 0;
  int         errors = 0;
  int         last_lat = 0;

  logic       pop_fire = 1'b0;
  logic [7:0] q_at_pop = '0;
  req_t       r;
  logic [7:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture pops like a flop so the monitor sees the head as it was popped.
  always @(posedge clk) begin
    pop_fire <= rd && ready;
    q_at_pop <= q;
  end

  always @(negedge clk) begin
    if (pop_fire) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected_byte", {24'd0, q_at_pop}, 32'h100);
      end else begin
        e = exp_q.pop_front();
        check("pop_q", {24'd0, q_at_pop}, {24'd0, e});
      end
    end
    if (req_q.size() != 0) begin
      r = req_q.pop_front();
      check($sformatf("s%0d_count", r.tag), 32'(count), 32'(r.cnt));
      check($sformatf("s%0d_ready", r.tag), 32'(ready), 32'(r.cnt != 0));
      check($sformatf("s%0d_ferr",  r.tag), 32'(ferr),  32'(r.ferr));
      check($sformatf("s%0d_ovr",   r.tag), 32'(ovr),   32'(r.ovr));
      if (r.lat_chk)
        check($sformatf("s%0d_ready_latency_%0d", r.tag, r.lat),
              32'(r.lat >= 16'd150 && r.lat <= 16'd158), 32'd1);
      if (r.sb_chk)
        check($sformatf("s%0d_sb_drained", r.tag), 32'(exp_q.size()), 32'd0);
    end
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic status(input int tag, input int cnt, input bit fe, input bit ov,
                        input bit lat_chk, input bit sb_chk);
    req_t t;
    t.tag     = 8'(tag);
    t.cnt     = 4'(cnt);
    t.ferr    = fe;
    t.ovr     = ov;
    t.lat_chk = lat_chk;
    t.sb_chk  = sb_chk;
    t.lat     = 16'(last_lat);
    req_q.push_back(t);
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  // One full frame, 10 bit times. rd_at / rst_at pulse rd or reset at a
  // given cycle offset from the start-bit falling edge.
  task automatic send(input logic [7:0] b, input bit stop, input int rd_at, input int rst_at);
    bit seen = 1'b0;
    for (int c = 0; c < 10 * BC; c++) begin
      @(negedge clk);
      if (c < BC)           rxd = 1'b0;
      else if (c < 9 * BC)  rxd = b[(c - BC) / BC];
      else                  rxd = stop;
      rd    = (c == rd_at);
      reset = (c >= rst_at) && (c < rst_at + 4);
      if (!seen && ready) begin
        seen     = 1'b1;
        last_lat = c;
      end
    end
    rd = 1'b0;
  endtask

  initial begin
    rxd = 1'b1; rd = 1'b0; clr = 1'b0; reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    idle(5);
    status(0, 0, 0, 0, 0, 0);

    // Single good frame
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, -1, -1000);
    idle(10);
    status(1, 1, 0, 0, 1, 0);
    pop_one();
    status(2, 0, 0, 0, 0, 1);

    // Five back-to-back frames into a 4-deep FIFO
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    send(8'hA5, 1'b1, -1, -1000);
    send(8'h3C, 1'b1, -1, -1000);
    send(8'hFF, 1'b1, -1, -1000);
    send(8'h00, 1'b1, -1, -1000);
    send(8'h81, 1'b1, -1, -1000);
    idle(10);
    status(3, 4, 0, 1, 0, 0);
    repeat (4) pop_one();
    status(4, 0, 0, 1, 0, 1);
    pulse_clr();
    status(5, 0, 0, 0, 0, 0);

    // Framing error, clear, then a good frame
    send(8'h42, 1'b0, -1, -1000);
    idle(20);
    status(6, 0, 1, 0, 0, 0);
    pulse_clr();
    status(7, 0, 0, 0, 0, 0);
    exp_q.push_back(8'h42);
    send(8'h42, 1'b1, -1, -1000);
    idle(10);
    status(8, 1, 0, 0, 0, 0);
    pop_one();
    status(9, 0, 0, 0, 0, 1);

    // Short glitch, then a long low stretch
    @(negedge clk) rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(100);
    status(10, 0, 0, 0, 0, 0);
    @(negedge clk) rxd = 1'b0;
    repeat (300) @(negedge clk);
    idle(300);
    status(11, 0, 1, 0, 0, 0);
    pulse_clr();
    status(12, 0, 0, 0, 0, 0);

    // Full FIFO with a pop on the push cycle
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    send(8'h11, 1'b1, -1, -1000);
    send(8'h22, 1'b1, -1, -1000);
    send(8'h33, 1'b1, -1, -1000);
    send(8'h44, 1'b1, -1, -1000);
    idle(10);
    status(13, 4, 0, 0, 0, 0);
    exp_q.push_back(8'h77);
    send(8'h77, 1'b1, 154, -1000);
    idle(10);
    status(14, 4, 0, 0, 0, 0);
    repeat (4) pop_one();
    status(15, 0, 0, 0, 0, 1);

    // Reset mid-DATA, released while the line is high
    send(8'h99, 1'b1, -1, 130);
    idle(300);
    status(16, 0, 0, 0, 0, 1);
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1, -1, -1000);
    idle(10);
    status(17, 1, 0, 0, 0, 0);
    pop_one();
    status(18, 0, 0, 0, 0, 1);

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
